// File: rtl/pc_fetch_unit.sv
// Program counter and fetch sequencer for the 16-bit single-cycle CPU.
// Selects the next fetch address from halt/jump/branch/sequential sources.
//
// state  | meaning
// BOOT   | first cycle after reset, fetch not yet valid, PC held at 0
// RUN    | fetching and retiring one instruction per unstalled cycle
// HALTED | HALT_WORD seen; PC and retire count frozen until reset
module pc_fetch_unit #(
    parameter int unsigned MEM_BYTES = 256,
    parameter logic [15:0] HALT_WORD = 16'h0000,
    parameter logic [3:0]  JUMP_OP   = 4'b0110
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Stall,
    input  logic        Branch_Taken,
    input  logic [15:0] Branch_Offset,
    input  logic [15:0] Instr_In,
    output logic [15:0] Instr_Addr,
    output logic [15:0] PC_Plus2,
    output logic        Instr_Valid,
    output logic        Halted,
    output logic [15:0] Retire_Count
);

    // Keeps every computed PC even and inside the memory window.
    localparam logic [15:0] PC_MASK = 16'(MEM_BYTES - 1) & 16'hFFFE;

    typedef enum logic [1:0] {
        BOOT   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t      state_q;
    logic [15:0] pc_q;
    logic [15:0] pc_d;
    logic [15:0] retire_q;
    logic [15:0] retire_d;
    logic        valid_q;
    logic        halted_q;
    logic [15:0] pc_plus2;
    logic [15:0] jump_tgt;
    logic [15:0] branch_tgt;
    logic        is_halt;
    logic        is_jump;

    always_comb begin
        pc_plus2   = (pc_q + 16'd2) & PC_MASK;
        jump_tgt   = {3'b000, Instr_In[11:0], 1'b0} & PC_MASK;
        branch_tgt = (pc_q + 16'd2 + (Branch_Offset << 1)) & PC_MASK;
        is_halt    = (Instr_In == HALT_WORD);
        is_jump    = (Instr_In[15:12] == JUMP_OP);

        pc_d = pc_plus2;
        if (is_jump) begin
            pc_d = jump_tgt;
        end else if (Branch_Taken) begin
            pc_d = branch_tgt;
        end

        retire_d = (retire_q == 16'hFFFF) ? retire_q : retire_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= BOOT;
            pc_q     <= 16'd0;
            retire_q <= 16'd0;
            valid_q  <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            case (state_q)
                BOOT: begin
                    state_q <= RUN;
                    valid_q <= 1'b1;
                end
                RUN: begin
                    // A stalled cycle re-presents the same fetch untouched.
                    if (!Stall) begin
                        if (is_halt) begin
                            state_q  <= HALTED;
                            valid_q  <= 1'b0;
                            halted_q <= 1'b1;
                        end else begin
                            pc_q     <= pc_d;
                            retire_q <= retire_d;
                        end
                    end
                end
                HALTED: begin
                    state_q  <= HALTED;
                    valid_q  <= 1'b0;
                    halted_q <= 1'b1;
                end
                default: begin
                    state_q  <= BOOT;
                    pc_q     <= 16'd0;
                    valid_q  <= 1'b0;
                    halted_q <= 1'b0;
                end
            endcase
        end
    end

    assign Instr_Addr   = pc_q;
    assign PC_Plus2     = pc_plus2;
    assign Instr_Valid  = valid_q;
    assign Halted       = halted_q;
    assign Retire_Count = retire_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: a small instruction/branch table stands in
// for memory and the datapath; expected values are hand-traced per vector.
module tb_pc_fetch_unit;

    logic        clk;
    logic        reset;
    logic        Stall;
    logic        Branch_Taken;
    logic [15:0] Branch_Offset;
    logic [15:0] Instr_In;
    logic [15:0] Instr_Addr;
    logic [15:0] PC_Plus2;
    logic        Instr_Valid;
    logic        Halted;
    logic [15:0] Retire_Count;

    logic [15:0] imem   [0:127];
    logic        br_tk  [0:127];
    logic [15:0] br_off [0:127];

    int n_vec;
    int n_err;

    pc_fetch_unit #(
        .MEM_BYTES(256),
        .HALT_WORD(16'h0000),
        .JUMP_OP  (4'b0110)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .Stall        (Stall),
        .Branch_Taken (Branch_Taken),
        .Branch_Offset(Branch_Offset),
        .Instr_In     (Instr_In),
        .Instr_Addr   (Instr_Addr),
        .PC_Plus2     (PC_Plus2),
        .Instr_Valid  (Instr_Valid),
        .Halted       (Halted),
        .Retire_Count (Retire_Count)
    );

    assign Instr_In      = imem[Instr_Addr[7:1]];
    assign Branch_Taken  = br_tk[Instr_Addr[7:1]];
    assign Branch_Offset = br_off[Instr_Addr[7:1]];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_state(input string tag, input logic [15:0] pc, input logic [15:0] cnt,
                               input logic valid, input logic halted);
        check_vec({tag, ".addr"},   32'(Instr_Addr),   32'(pc));
        check_vec({tag, ".plus2"},  32'(PC_Plus2),     32'((pc + 16'd2) & 16'h00FE));
        check_vec({tag, ".retire"}, 32'(Retire_Count), 32'(cnt));
        check_vec({tag, ".valid"},  32'(Instr_Valid),  32'(valid));
        check_vec({tag, ".halted"}, 32'(Halted),       32'(halted));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_default();
        for (int i = 0; i < 128; i++) begin
            imem[i]   = 16'h1000;
            br_tk[i]  = 1'b0;
            br_off[i] = 16'h0000;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        check_state("rst", 16'd0, 16'd0, 1'b0, 1'b0);
        reset = 1'b0;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        reset = 1'b1;
        Stall = 1'b0;
        load_default();

        // Straight line, jump at 8, jump-with-branch at 22, branch at 14, halt at 20
        imem[4]   = 16'h600B;
        imem[11]  = 16'h6005;
        br_tk[11] = 1'b1;
        br_off[11] = 16'h0004;
        br_tk[7]  = 1'b1;
        br_off[7] = 16'h0002;
        imem[10]  = 16'h0000;
        do_reset();
        step(); check_state("boot",  16'd0,  16'd0, 1'b1, 1'b0);
        step(); check_state("seq2",  16'd2,  16'd1, 1'b1, 1'b0);
        step(); check_state("seq4",  16'd4,  16'd2, 1'b1, 1'b0);
        step(); check_state("seq6",  16'd6,  16'd3, 1'b1, 1'b0);
        step(); check_state("seq8",  16'd8,  16'd4, 1'b1, 1'b0);
        step(); check_state("jmp22", 16'd22, 16'd5, 1'b1, 1'b0);
        step(); check_state("jprio", 16'd10, 16'd6, 1'b1, 1'b0);
        step(); check_state("seq12", 16'd12, 16'd7, 1'b1, 1'b0);
        step(); check_state("seq14", 16'd14, 16'd8, 1'b1, 1'b0);
        step(); check_state("br20",  16'd20, 16'd9, 1'b1, 1'b0);
        step(); check_state("halt",  16'd20, 16'd9, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) begin
            step(); check_state("hfrz", 16'd20, 16'd9, 1'b0, 1'b1);
        end
        do_reset();

        // Backward branch below zero, sequential wrap, stall with late offset change
        load_default();
        br_tk[2]  = 1'b1;
        br_off[2] = 16'hFFFC;
        do_reset();
        step(); check_state("b.boot", 16'd0,   16'd0, 1'b1, 1'b0);
        step(); check_state("b.s2",   16'd2,   16'd1, 1'b1, 1'b0);
        step(); check_state("b.s4",   16'd4,   16'd2, 1'b1, 1'b0);
        step(); check_state("b.bwd",  16'd254, 16'd3, 1'b1, 1'b0);
        step(); check_state("b.wrap", 16'd0,   16'd4, 1'b1, 1'b0);
        br_tk[2] = 1'b0;
        step(); check_state("b.s2b",  16'd2,   16'd5, 1'b1, 1'b0);
        step(); check_state("b.s4b",  16'd4,   16'd6, 1'b1, 1'b0);
        step(); check_state("b.s6",   16'd6,   16'd7, 1'b1, 1'b0);
        br_tk[4]  = 1'b1;
        br_off[4] = 16'h0003;
        step(); check_state("b.s8",   16'd8,   16'd8, 1'b1, 1'b0);
        Stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(); check_state("b.stl", 16'd8, 16'd8, 1'b1, 1'b0);
            if (i == 1) br_off[4] = 16'h0005;
        end
        Stall = 1'b0;
        step(); check_state("b.rel",  16'd20,  16'd9, 1'b1, 1'b0);
        imem[10] = 16'h6030;
        do_reset();

        // Stall ignored in BOOT, then retire count saturation
        load_default();
        reset = 1'b1;
        Stall = 1'b1;
        step();
        reset = 1'b0;
        step(); check_state("d.boot", 16'd0, 16'd0, 1'b1, 1'b0);
        step(); check_state("d.stl",  16'd0, 16'd0, 1'b1, 1'b0);
        Stall = 1'b0;
        repeat (65534) step();
        check_state("d.fffe", 16'd252, 16'hFFFE, 1'b1, 1'b0);
        step(); check_state("d.ffff", 16'd254, 16'hFFFF, 1'b1, 1'b0);
        step(); step(); step();
        check_state("d.sat",  16'd4, 16'hFFFF, 1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1);
    end

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Program-counter and fetch-sequencing stage of the 16-bit single-cycle CPU, directly upstream of the byte-addressed instruction memory.
- Drives the fetch byte address and receives the 16-bit big-endian instruction word back.
- Selects the next PC from sequential, jump and taken-branch sources.
- Also handles stall, halt detection and a retired-instruction counter.

Parameters:
MEM_BYTES, 256, instruction memory size in bytes; power of two, at least 4; fetch addresses wrap modulo this value
HALT_WORD, 16'h0000, instruction encoding that halts fetch (unprogrammed memory reads as zero)
JUMP_OP, 4'b0110, opcode in Instr_In[15:12] that marks an unconditional jump

Ports:
clk  input  1  single clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
Stall  input  1  datapath hold request; PC and counter freeze
Branch_Taken  input  1  from datapath: current instruction is a branch and its condition is true
Branch_Offset  input  16  signed word offset for the current branch, already sign-extended by the decoder
Instr_In  input  16  instruction word returned by instruction memory for Instr_Addr
Instr_Addr  output  16  fetch byte address to instruction memory; always even
PC_Plus2  output  16  Instr_Addr + 2, wrapped modulo MEM_BYTES; used for link and branch base
Instr_Valid  output  1  Instr_In is a live instruction to be executed this cycle
Halted  output  1  fetch stopped on HALT_WORD
Retire_Count  output  16  count of instructions retired since reset; saturating

Behaviour:
- Reset (synchronous): state=BOOT, PC=0, Instr_Valid=0, Halted=0, Retire_Count=0. Reset wins over every other input. Asserting it mid-run or while HALTED returns all of these values on the next edge.
- Outputs: Instr_Addr=PC. PC_Plus2=(PC+2) mod MEM_BYTES, combinational from PC.
- States:
  - BOOT: one cycle with Instr_Valid=0 and PC held; then RUN unconditionally. Stall is ignored in BOOT.
  - RUN: Instr_Valid=1.
  - HALTED: Instr_Valid=0, Halted=1, PC and Retire_Count frozen. Only reset exits HALTED.
- Next-PC priority in RUN with Stall=0:
  1. Instr_In==HALT_WORD: go to HALTED. PC holds. Retire_Count unchanged; the halt word is not retired.
  2. Instr_In[15:12]==JUMP_OP: PC <= ({3'b0, Instr_In[11:0], 1'b0}) mod MEM_BYTES.
  3. Branch_Taken=1: PC <= (PC + 2 + (Branch_Offset<<1)) mod MEM_BYTES. Arithmetic is 16-bit two's complement, truncated, then masked.
  4. Otherwise: PC <= PC_Plus2.
- On any non-halt next-PC in RUN with Stall=0, Retire_Count increments by 1. It saturates at 16'hFFFF with no wrap.
- Jump and Branch_Taken both asserted: the jump wins; Branch_Taken is ignored.
- Stall=1 in RUN:
  - PC, state and Retire_Count hold.
  - Instr_Valid stays 1 and the same Instr_Addr is presented.
  - Halt, jump and branch are not evaluated until a cycle with Stall=0.
- Bit 0 of every computed PC is forced to 0; bits at or above log2(MEM_BYTES) are forced to 0.
- Wrap-around: sequential fetch from MEM_BYTES-2 goes to 0. Backward branches below 0 wrap to the top of memory.
- Latency: one cycle from a redirect decision to the new Instr_Addr. There is no delay slot, so the instruction at the new address is valid on the next cycle.

Test Plan:
1. Reset, then run straight-line code (no jump/branch, non-zero words): BOOT for 1 cycle with Instr_Valid=0; Instr_Addr then steps 0,2,4,6; Retire_Count=3 when Instr_Addr=6.
2. Instr_Addr=22 with Instr_In=16'h6005 -> next Instr_Addr=10 and Retire_Count increments. Same case with Branch_Taken=1 and Branch_Offset=4 also -> Instr_Addr=10 (jump priority).
3. Branch:
   - Instr_Addr=14, Branch_Taken=1, Branch_Offset=16'h0002 -> Instr_Addr=20.
   - Instr_Addr=4, Branch_Offset=16'hFFFC -> (4+2-8) mod 256 = Instr_Addr 254.
4. Stall held 3 cycles at Instr_Addr=8 with Branch_Taken=1 -> Instr_Addr stays 8, Retire_Count constant, Instr_Valid=1. On release, branch taken with the then-current Branch_Offset.
5. Fetch reaches an address holding 16'h0000 -> Halted=1 and Instr_Valid=0 next cycle, PC frozen, Retire_Count frozen for 10 further cycles. Reset then gives Halted=0, PC=0, state BOOT.
6. MEM_BYTES=256, sequential fetch at 254 -> Instr_Addr=0. Separately, force Retire_Count to 16'hFFFF -> it stays 16'hFFFF after further retirements. Separately, assert reset in the same cycle as a jump -> PC=0.
